// File: rtl/monitor_symbol_encoder.sv
// ----------------------------------------------------------------------------
// monitor_symbol_encoder
//
// Producer side of the runtime-monitor symbol interface. Up to two commit-stage
// events per cycle are encoded as {class, tag} bytes and buffered in a small
// FIFO. The FIFO drains one symbol per cycle towards the monitor automata,
// which never back-pressure. A flush request clears the encoder and produces a
// reset pulse for the automata.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   flush_req             clear the encoder and restart the monitor automata
//   commit_valid[1:0]     per-port event valid, bit0 is the older event
//   commit_class0/tag0    port0 event class / attribute
//   commit_class1/tag1    port1 event class / attribute
//   symbols, run          registered symbol to the monitor and its valid
//   mon_reset             reset pulse to the monitor automata (FLUSH state)
//   enc_stall             fewer than two free entries, core should hold commit
//   overflow              sticky, set when any event is dropped
//   drop_count            saturating count of dropped events
//   fifo_level            current FIFO occupancy
//
// Optional feature, macro MON_IDLE_SYMBOL_EN:
//   When defined, an empty FIFO in RUN emits idle symbol 8'hFF with run=1, and
//   a commit that would encode to the reserved 8'hFF is remapped to 8'hFE.
//   When undefined, an empty FIFO gives run=0 and no remapping occurs.
// ----------------------------------------------------------------------------
module monitor_symbol_encoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_req,
    input  logic [1:0]       commit_valid,
    input  logic [2:0]       commit_class0,
    input  logic [4:0]       commit_tag0,
    input  logic [2:0]       commit_class1,
    input  logic [4:0]       commit_tag1,
    output logic [7:0]       symbols,
    output logic             run,
    output logic             mon_reset,
    output logic             enc_stall,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic [AW:0]      fifo_level
);

    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   wr_ptr_inc;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     free;
    logic [AW:0]     level_next;
    logic            push0;
    logic            push1;
    logic            pop;
    logic [1:0]      drop_n;
    logic [CNT_W:0]  cnt_sum;
    logic [7:0]      sym0;
    logic [7:0]      sym1;

    function automatic logic [7:0] encode(input logic [2:0] cls, input logic [4:0] tag);
        logic [7:0] s;
        s = {cls, tag};
`ifdef MON_IDLE_SYMBOL_EN
        // 8'hFF is reserved for the idle symbol
        if (s == 8'hFF) s = 8'hFE;
`endif
        return s;
    endfunction

    assign sym0       = encode(commit_class0, commit_tag0);
    assign sym1       = encode(commit_class1, commit_tag1);
    assign free       = DEPTH - fifo_level;
    assign wr_ptr_inc = wr_ptr + AW'(1);
    assign mon_reset  = (state == ST_FLUSH);

    // Free space is judged on the level at the start of the cycle; the
    // same-cycle pop is deliberately not credited. Port0 always has priority.
    always_comb begin
        state_next = state;
        push0      = 1'b0;
        push1      = 1'b0;
        pop        = 1'b0;
        drop_n     = 2'd0;
        if (flush_req) begin
            state_next = ST_FLUSH;
        end else begin
            state_next = ST_RUN;
            pop        = (state == ST_RUN) && (fifo_level != '0);
            if (free >= (AW+1)'(2)) begin
                push0 = commit_valid[0];
                push1 = commit_valid[1];
            end else if (free == (AW+1)'(1)) begin
                push0  = commit_valid[0];
                push1  = commit_valid[1] & ~commit_valid[0];
                drop_n = {1'b0, &commit_valid};
            end else begin
                drop_n = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};
            end
        end
    end

    // Next occupancy drives both the level register and the registered stall
    always_comb begin
        level_next = fifo_level;
        if (flush_req) begin
            level_next = '0;
        end else begin
            level_next = fifo_level + {{AW{1'b0}}, push0} + {{AW{1'b0}}, push1}
                         - {{AW{1'b0}}, pop};
        end
    end

    assign cnt_sum = {1'b0, drop_count} + {{(CNT_W-1){1'b0}}, drop_n};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FIFO pointers, level and stall; pointers wrap naturally and the level
    // counter distinguishes full from empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            enc_stall  <= 1'b0;
        end else begin
            fifo_level <= level_next;
            enc_stall  <= (DEPTH - level_next) < (AW+1)'(2);
            if (flush_req) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, push0} + {{(AW-1){1'b0}}, push1};
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Drop statistics; the counter saturates instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (flush_req) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop_n != 2'd0) begin
            overflow   <= 1'b1;
            drop_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    // Storage needs no reset; occupancy is tracked by the level counter.
    // Port1 lands behind port0 when both are pushed.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem[wr_ptr] <= sym0;
        end
        if (push1) begin
            mem[push0 ? wr_ptr_inc : wr_ptr] <= sym1;
        end
    end

    // Symbol output register: head of the FIFO is presented the cycle after
    // it is popped; flush and the FLUSH state keep run low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            symbols <= 8'h00;
            run     <= 1'b0;
        end else if (flush_req) begin
            symbols <= 8'h00;
            run     <= 1'b0;
        end else if (pop) begin
            symbols <= mem[rd_ptr];
            run     <= 1'b1;
`ifdef MON_IDLE_SYMBOL_EN
        end else if (state == ST_RUN) begin
            symbols <= 8'hFF;
            run     <= 1'b1;
`endif
        end else begin
            symbols <= 8'h00;
            run     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_monitor_symbol_encoder.sv
// ----------------------------------------------------------------------------
// tb_monitor_symbol_encoder
//
// Directed bench for monitor_symbol_encoder (default build, FIFO_DEPTH=8,
// CNT_W=8). Accepted events are queued as expected symbols when issued; a
// monitor pops and compares every symbol the DUT presents with run=1. Status
// outputs are compared directly against hand-derived values.
// ----------------------------------------------------------------------------
module tb_monitor_symbol_encoder;

    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush_req = 1'b0;
    logic [1:0]       commit_valid = 2'b00;
    logic [2:0]       commit_class0 = 3'd0;
    logic [4:0]       commit_tag0 = 5'd0;
    logic [2:0]       commit_class1 = 3'd0;
    logic [4:0]       commit_tag1 = 5'd0;
    logic [7:0]       symbols;
    logic             run;
    logic             mon_reset;
    logic             enc_stall;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
    logic [3:0]       fifo_level;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    monitor_symbol_encoder #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush_req(flush_req),
        .commit_valid(commit_valid),
        .commit_class0(commit_class0),
        .commit_tag0(commit_tag0),
        .commit_class1(commit_class1),
        .commit_tag1(commit_tag1),
        .symbols(symbols),
        .run(run),
        .mon_reset(mon_reset),
        .enc_stall(enc_stall),
        .overflow(overflow),
        .drop_count(drop_count),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // One comparison of a DUT output against a bench-derived value
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, record which events are
    // expected to be accepted, and return just after the sampling edge
    task automatic applyStimulus(input logic fl, input logic [1:0] v,
                                 input logic [2:0] c0, input logic [4:0] t0,
                                 input logic [2:0] c1, input logic [4:0] t1,
                                 input logic [1:0] acc);
        @(negedge clk);
        flush_req     = fl;
        commit_valid  = v;
        commit_class0 = c0;
        commit_tag0   = t0;
        commit_class1 = c1;
        commit_tag1   = t1;
        if (acc[0]) exp_q.push_back({c0, t0});
        if (acc[1]) exp_q.push_back({c1, t1});
        @(posedge clk);
        #1;
        flush_req    = 1'b0;
        commit_valid = 2'b00;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 2'b00, 3'd0, 5'd0, 3'd0, 5'd0, 2'b00);
        end
    endtask

    // Scoreboard monitor: every presented symbol must be the oldest expected
    always @(negedge clk) begin
        if (!reset && run) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_symbol: got %0h, expected none", symbols);
            end else begin
                mon_exp = exp_q.pop_front();
                if (symbols !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL symbol_stream: got %0h, expected %0h", symbols, mon_exp);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("reset_symbols", symbols, 8'h00);
        checkOutput("reset_run", run, 1'b0);
        checkOutput("reset_mon_reset", mon_reset, 1'b0);
        checkOutput("reset_enc_stall", enc_stall, 1'b0);
        checkOutput("reset_overflow", overflow, 1'b0);
        checkOutput("reset_drop_count", drop_count, 8'h00);
        checkOutput("reset_fifo_level", fifo_level, 4'd0);
        reset = 1'b0;

        // Single event, one-cycle latency after the push edge
        applyStimulus(1'b0, 2'b01, 3'b010, 5'h05, 3'd0, 5'd0, 2'b01);
        checkOutput("single_level", fifo_level, 4'd1);
        checkOutput("single_run_early", run, 1'b0);
        idleCycles(1);
        checkOutput("single_run", run, 1'b1);
        checkOutput("single_symbol", symbols, 8'h45);
        idleCycles(1);
        checkOutput("single_run_after", run, 1'b0);
        checkOutput("single_symbol_after", symbols, 8'h00);

        // Only port1 valid: a single entry
        applyStimulus(1'b0, 2'b10, 3'd0, 5'd0, 3'b101, 5'h1A, 2'b10);
        checkOutput("port1_only_level", fifo_level, 4'd1);
        idleCycles(1);
        checkOutput("port1_only_symbol", symbols, 8'hBA);
        idleCycles(2);

        // Continuous dual-port burst: level 2,3,4,5,6,7 then port1 drops
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 2'b11, 3'(i), 5'(2*i), 3'(~i), 5'(2*i+1),
                          (i < 6) ? 2'b11 : 2'b01);
            if (i == 4) begin
                checkOutput("burst_level6", fifo_level, 4'd6);
                checkOutput("burst_stall_low", enc_stall, 1'b0);
            end
            if (i == 5) begin
                checkOutput("burst_level7", fifo_level, 4'd7);
                checkOutput("burst_stall_high", enc_stall, 1'b1);
                checkOutput("burst_no_overflow", overflow, 1'b0);
            end
            if (i == 6) begin
                checkOutput("free1_level_holds", fifo_level, 4'd7);
                checkOutput("free1_drop_count", drop_count, 8'd1);
                checkOutput("free1_overflow", overflow, 1'b1);
            end
            if (i == 7) begin
                checkOutput("burst_drop_count", drop_count, 8'd2);
            end
        end
        idleCycles(9);
        checkOutput("drain_level", fifo_level, 4'd0);
        checkOutput("drain_stall", enc_stall, 1'b0);
        checkOutput("drain_queue_empty", exp_q.size(), 0);
        checkOutput("drain_overflow_sticky", overflow, 1'b1);

        // Flush at level 5 with both ports valid
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'b11, 3'(i+1), 5'(i+7), 3'(i+4), 5'(i+20), 2'b11);
        end
        checkOutput("preflush_level", fifo_level, 4'd5);
        applyStimulus(1'b1, 2'b11, 3'd6, 5'd9, 3'd2, 5'd3, 2'b00);
        exp_q.delete();
        checkOutput("flush_mon_reset", mon_reset, 1'b1);
        checkOutput("flush_run", run, 1'b0);
        checkOutput("flush_level", fifo_level, 4'd0);
        checkOutput("flush_overflow", overflow, 1'b0);
        checkOutput("flush_drop_count", drop_count, 8'd0);
        applyStimulus(1'b0, 2'b01, 3'b001, 5'h11, 3'd0, 5'd0, 2'b01);
        checkOutput("postflush_mon_reset", mon_reset, 1'b0);
        checkOutput("postflush_level", fifo_level, 4'd1);
        checkOutput("postflush_run", run, 1'b0);
        idleCycles(1);
        checkOutput("postflush_symbol", symbols, 8'h31);
        idleCycles(1);

        // Two-cycle flush request extends mon_reset
        applyStimulus(1'b1, 2'b00, 3'd0, 5'd0, 3'd0, 5'd0, 2'b00);
        checkOutput("flush2_first", mon_reset, 1'b1);
        applyStimulus(1'b1, 2'b11, 3'd5, 5'd5, 3'd6, 5'd6, 2'b00);
        checkOutput("flush2_second", mon_reset, 1'b1);
        checkOutput("flush2_level", fifo_level, 4'd0);
        idleCycles(1);
        checkOutput("flush2_end", mon_reset, 1'b0);
        checkOutput("flush2_run", run, 1'b0);

        // Saturation: fill to 7, then 300 cycles dropping port1 each time
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 2'b11, 3'(i), 5'(i+1), 3'(i+3), 5'(3*i), 2'b11);
        end
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b0, 2'b11, 3'(k), 5'(k+1), 3'(k+3), 5'(3*k), 2'b01);
            if (k == 0)   checkOutput("sat_first_drop", drop_count, 8'd1);
            if (k == 254) checkOutput("sat_reach", drop_count, 8'hFF);
            if (k == 299) begin
                checkOutput("sat_no_wrap", drop_count, 8'hFF);
                checkOutput("sat_level", fifo_level, 4'd7);
            end
        end

        // Asynchronous reset mid-burst, between clock edges
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_symbols", symbols, 8'h00);
        checkOutput("areset_run", run, 1'b0);
        checkOutput("areset_level", fifo_level, 4'd0);
        checkOutput("areset_overflow", overflow, 1'b0);
        checkOutput("areset_drop_count", drop_count, 8'h00);
        checkOutput("areset_stall", enc_stall, 1'b0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1'b0, 2'b01, 3'b011, 5'h0C, 3'd0, 5'd0, 2'b01);
        checkOutput("post_reset_level", fifo_level, 4'd1);
        idleCycles(1);
        checkOutput("post_reset_run", run, 1'b1);
        checkOutput("post_reset_symbol", symbols, 8'h6C);
        idleCycles(3);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
